// File: rtl/spi_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_pkg
// Description : Shared frame constants, state encoding and default idle byte
//               for the SPI slave endpoint.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_slave_pkg;

    // Frame width and the bit counter width needed to index it
    localparam int SPI_BITS  = 8;
    localparam int SPI_CNT_W = $clog2(SPI_BITS);

    // {CPOL, CPHA}: idle-low clock, sample on rising, change on falling
    localparam logic [1:0] SPI_MODE0 = 2'b00;

    // Byte presented to the master when nothing has been loaded
    localparam logic [SPI_BITS-1:0] SPI_IDLE_BYTE_DEFAULT = 8'hFF;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } spi_state_e;

    // Byte to start shifting at a byte boundary: buffered data or filler
    function automatic logic [SPI_BITS-1:0] pick_tx_byte(
        input logic                full,
        input logic [SPI_BITS-1:0] buf_val,
        input logic [SPI_BITS-1:0] idle_val
    );
        return full ? buf_val : idle_val;
    endfunction

endpackage : spi_slave_pkg
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : spi_sync_edge
// Description : Multi-flop synchroniser for one asynchronous bus input, with
//               single-cycle rise/fall pulses derived from a delayed copy.
//               SYNC_STAGES must be at least 2.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   dly_q,  dly_d;

    // Shift the raw input through the chain; keep one extra delayed copy
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
        dly_d  = sync_q[SYNC_STAGES-1];
    end

    // Synchroniser and delay flops; reset to the bus idle level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            dly_q  <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  =  level & ~dly_q;
    assign fall  = ~level &  dly_q;

endmodule : spi_sync_edge
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave
// Description : Mode-0, MSB-first, 8-bit SPI peripheral endpoint. All bus
//               inputs are oversampled into clk. Provides a received-byte
//               register and a one-deep transmit holding buffer.
//               Optional macro SPI_SLAVE_OVERRUN_EN adds the sticky ovr flag.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int                  SYNC_STAGES = 2,
    parameter logic [SPI_BITS-1:0] IDLE_BYTE   = SPI_IDLE_BYTE_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ss_n,
    input  logic                sck,
    input  logic                mosi,
    output logic                miso,
    output logic                miso_oe,
    input  logic [SPI_BITS-1:0] DIN,
    input  logic                load,
    output logic                tx_empty,
    output logic [SPI_BITS-1:0] DOUT,
    output logic                rx_valid,
    output logic                rx_full,
    input  logic                rd,
    output logic                active
`ifdef SPI_SLAVE_OVERRUN_EN
    ,
    output logic                ovr
`endif
);

    // ------------------------------------------------------------------
    // Bus input synchronisation
    // ------------------------------------------------------------------
    logic sck_lvl,  sck_rise,  sck_fall;
    logic ss_lvl,   ss_rise,   ss_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk(clk), .rst(rst), .d(sck),
        .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
    );

    // ss_n idles high, so its chain resets high to avoid a false edge
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk(clk), .rst(rst), .d(ss_n),
        .level(ss_lvl), .rise(ss_rise), .fall(ss_fall)
    );

    // Same depth as sck so mosi stays aligned with the sampling edge
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .d(mosi),
        .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
    );

    // Only the sck edges and the mosi level are needed
    logic unused_sync;
    assign unused_sync = &{1'b0, sck_lvl, mosi_rise, mosi_fall};

    // ------------------------------------------------------------------
    // Core state
    // ------------------------------------------------------------------
    spi_state_e             state_q,    state_d;
    logic [SPI_CNT_W-1:0]   bit_cnt_q,  bit_cnt_d;
    logic [SPI_BITS-2:0]    rx_sh_q,    rx_sh_d;
    logic [SPI_BITS-1:0]    tx_sh_q,    tx_sh_d;
    logic                   miso_q,     miso_d;
    logic [SPI_BITS-1:0]    dout_q,     dout_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   rx_full_q,  rx_full_d;
    logic [SPI_BITS-1:0]    buf_q,      buf_d;
    logic                   buf_full_q, buf_full_d;

    logic                   consume;
    logic                   byte_done;
    logic [SPI_BITS-1:0]    tx_byte;

    // Frame FSM, shifters, receive register and transmit buffer update
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_sh_d    = rx_sh_q;
        tx_sh_d    = tx_sh_q;
        miso_d     = miso_q;
        dout_d     = dout_q;
        rx_valid_d = 1'b0;
        rx_full_d  = rx_full_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        consume    = 1'b0;
        byte_done  = 1'b0;
        tx_byte    = pick_tx_byte(buf_full_q, buf_q, IDLE_BYTE);

        if (rd) begin
            rx_full_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (ss_fall) begin
                    state_d   = ST_SHIFT;
                    consume   = 1'b1;
                    miso_d    = tx_byte[SPI_BITS-1];
                    tx_sh_d   = tx_byte << 1;
                    bit_cnt_d = '0;
                end
            end
            ST_SHIFT: begin
                if (ss_rise) begin
                    // Any partial byte is simply dropped
                    state_d = ST_IDLE;
                    miso_d  = 1'b0;
                end else if (sck_rise) begin
                    rx_sh_d   = {rx_sh_q[SPI_BITS-3:0], mosi_lvl};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == SPI_CNT_W'(SPI_BITS - 1)) begin
                        byte_done  = 1'b1;
                        dout_d     = {rx_sh_q, mosi_lvl};
                        rx_valid_d = 1'b1;
                        rx_full_d  = 1'b1;
                        tx_sh_d    = tx_byte;
                        consume    = 1'b1;
                    end
                end else if (sck_fall) begin
                    miso_d  = tx_sh_q[SPI_BITS-1];
                    tx_sh_d = tx_sh_q << 1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A load alongside a consume keeps the new byte buffered
        if (load) begin
            buf_d      = DIN;
            buf_full_d = 1'b1;
        end else if (consume) begin
            buf_full_d = 1'b0;
        end
    end

    // Core registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            rx_sh_q    <= '0;
            tx_sh_q    <= '0;
            miso_q     <= 1'b0;
            dout_q     <= '0;
            rx_valid_q <= 1'b0;
            rx_full_q  <= 1'b0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_sh_q    <= rx_sh_d;
            tx_sh_q    <= tx_sh_d;
            miso_q     <= miso_d;
            dout_q     <= dout_d;
            rx_valid_q <= rx_valid_d;
            rx_full_q  <= rx_full_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
        end
    end

    assign miso     = miso_q;
    assign miso_oe  = (state_q == ST_SHIFT);
    assign tx_empty = ~buf_full_q;
    assign DOUT     = dout_q;
    assign rx_valid = rx_valid_q;
    assign rx_full  = rx_full_q;
    assign active   = ~ss_lvl;

`ifdef SPI_SLAVE_OVERRUN_EN
    logic ovr_q, ovr_d;

    // Sticky overrun: byte lands on an unread DOUT; cleared at frame end
    always_comb begin
        ovr_d = ovr_q;
        if (ss_rise) begin
            ovr_d = 1'b0;
        end else if (byte_done && rx_full_q && !rd) begin
            ovr_d = 1'b1;
        end
    end

    // Overrun flag register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign ovr = ovr_q;
`else
    logic unused_done;
    assign unused_done = byte_done;
`endif

endmodule : spi_slave
`default_nettype wire
